sipo_deser: RTL

- Serial-in/parallel-out receiver: the far end of a serial link driven by a shifting transmitter.
- Collects N serial bits into a word, in MSB-first or LSB-first order.
- Presents the completed word on a one-entry output buffer with a valid/ready handshake.
- Flags overrun when the consumer stalls and a new word is lost.

---
 rtl/sipo_deser.sv | 77 +++++++
 1 files changed

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out receiver with a one-entry valid/ready output buffer and sticky overrun.
// Define SIPO_DESER_PARITY_EN to append an even-parity bit to every frame and report it on parity_err.
module sipo_deser #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sin,
    input  logic          sin_valid,
    input  logic          sin_sync,
    input  logic          msb_first,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          overrun,
    input  logic          clr_ovr,
    output logic          parity_err,
    output logic [CW-1:0] bit_cnt
);
`ifdef SIPO_DESER_PARITY_EN
    localparam int LAST = N;
`else
    localparam int LAST = N - 1;
`endif
    logic [N-1:0]  sreg_q, sreg_d, dout_q, dout_d, shifted, word;
    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic          order_q, order_d, ord, dv_q, dv_d, ovr_q, ovr_d, perr_q, perr_d;
    logic          done, take, word_perr;
    always_comb begin
        // A sync restarts the frame, so this very bit is treated as bit #0.
        cnt_eff   = sin_sync ? '0 : cnt_q;
        ord       = (cnt_eff == '0) ? msb_first : order_q;
        shifted   = ord ? {sreg_q[N-2:0], sin} : {sin, sreg_q[N-1:1]};
        done      = sin_valid && (cnt_eff == CW'(LAST));
        take      = !dv_q || dout_ready;
`ifdef SIPO_DESER_PARITY_EN
        word      = sreg_q;
        word_perr = ^{sreg_q, sin};
        sreg_d    = (sin_valid && !done) ? shifted : sreg_q;
`else
        word      = shifted;
        word_perr = 1'b0;
        sreg_d    = sin_valid ? shifted : sreg_q;
`endif
        order_d   = sin_valid ? ord : order_q;
        cnt_d     = done ? '0 : sin_valid ? cnt_eff + 1'b1 : cnt_eff;
        dout_d    = (done && take) ? word : dout_q;
        perr_d    = (done && take) ? word_perr : perr_q;
        dv_d      = (done && take) || (dv_q && !dout_ready);
        ovr_d     = (done && !take) || (ovr_q && !clr_ovr);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q  <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign overrun    = ovr_q;
    assign parity_err = perr_q;
    assign bit_cnt    = cnt_q;
endmodule
